// File: rtl/playfield_pkg.sv
// Shared types and helpers for the playfield store.
// Holds the controller state enum, coordinate/address width helpers and
// the piece-window cell index used by every playfield file.
package playfield_pkg;

    typedef enum logic [1:0] {
        eIDLE,
        eBLOCK,
        eCLEAR
    } state_e;

    // Bits needed to address n rows or columns (never less than one bit).
    function automatic int addrW(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // Signed coordinate width: one sign bit on top of the address width.
    function automatic int coordW(input int n);
        return $clog2(n) + 1;
    endfunction

    // Bit position of piece cell (row r, column c) inside a dim x dim window.
    function automatic int cellIdx(input int r, input int c, input int dim);
        return r * dim + c;
    endfunction

endpackage

// File: rtl/playfield_memory_if.sv
// Bus bundle between the game executor / renderer and playfield_memory.
// The master modport is the executor/scanner side, the slave modport is the store.
interface playfield_memory_if
    import playfield_pkg::*;
#(
    parameter int width_p      = 10,
    parameter int height_p     = 20,
    parameter int piece_dim_p  = 4,
    parameter int line_ports_p = 2
);

    localparam int RowAW = addrW(height_p);
    localparam int XW    = coordW(width_p);
    localparam int YW    = coordW(height_p);
    localparam int Cells = piece_dim_p * piece_dim_p;

    logic [line_ports_p*RowAW-1:0]   line_addr_i;
    logic [line_ports_p*width_p-1:0] line_data_o;

    logic [XW-1:0]                   blk_rd_x_i;
    logic [YW-1:0]                   blk_rd_y_i;
    logic [Cells-1:0]                blk_rd_data_o;

    logic                            blk_w_v_i;
    logic                            blk_w_ready_o;
    logic [XW-1:0]                   blk_w_x_i;
    logic [YW-1:0]                   blk_w_y_i;
    logic [Cells-1:0]                blk_w_data_i;

    logic                            clr_v_i;
    logic                            clr_ready_o;
    logic [RowAW-1:0]                clr_row_i;

    logic                            row_w_v_i;
    logic                            row_w_ready_o;
    logic [RowAW-1:0]                row_w_addr_i;
    logic [width_p-1:0]              row_w_data_i;

    logic [height_p-1:0]             full_rows_o;
    logic                            done_o;
    logic                            collision_o;

    modport master (
        output line_addr_i,
        input  line_data_o,
        output blk_rd_x_i,
        output blk_rd_y_i,
        input  blk_rd_data_o,
        output blk_w_v_i,
        input  blk_w_ready_o,
        output blk_w_x_i,
        output blk_w_y_i,
        output blk_w_data_i,
        output clr_v_i,
        input  clr_ready_o,
        output clr_row_i,
        output row_w_v_i,
        input  row_w_ready_o,
        output row_w_addr_i,
        output row_w_data_i,
        input  full_rows_o,
        input  done_o,
        input  collision_o
    );

    modport slave (
        input  line_addr_i,
        output line_data_o,
        input  blk_rd_x_i,
        input  blk_rd_y_i,
        output blk_rd_data_o,
        input  blk_w_v_i,
        output blk_w_ready_o,
        input  blk_w_x_i,
        input  blk_w_y_i,
        input  blk_w_data_i,
        input  clr_v_i,
        output clr_ready_o,
        input  clr_row_i,
        input  row_w_v_i,
        output row_w_ready_o,
        input  row_w_addr_i,
        input  row_w_data_i,
        output full_rows_o,
        output done_o,
        output collision_o
    );

endinterface

// File: rtl/playfield_window.sv
// Combinational dim x dim window extractor over the playfield matrix.
// Cells left/right of the field or below the floor read as 1 (solid),
// cells above the top row inside the side walls read as 0 (spawn zone).
module playfield_window
    import playfield_pkg::*;
#(
    parameter int width_p  = 10,
    parameter int height_p = 20,
    parameter int dim_p    = 4
)
(
    input  logic [width_p-1:0]          mem_i [height_p],
    input  logic [coordW(width_p)-1:0]  x_i,
    input  logic [coordW(height_p)-1:0] y_i,
    output logic [dim_p*dim_p-1:0]      data_o
);

    localparam int CA = coordW(width_p) - 1;
    localparam int RA = coordW(height_p) - 1;

    for (genvar r = 0; r < dim_p; r++) begin : gRow
        for (genvar c = 0; c < dim_p; c++) begin : gCol
            logic [CA+1:0] colIdx;
            logic [RA+1:0] rowIdx;
            logic          solid;

            // Indices are widened by one bit so an offset origin never wraps.
            assign colIdx = {x_i[CA], x_i} + (CA+2)'(c);
            assign rowIdx = {y_i[RA], y_i} + (RA+2)'(r);
            assign solid  = colIdx[CA+1] || (int'(colIdx) >= width_p) ||
                            (!rowIdx[RA+1] && (int'(rowIdx) >= height_p));

            assign data_o[cellIdx(r, c, dim_p)] =
                solid        ? 1'b1 :
                rowIdx[RA+1] ? 1'b0 :
                               mem_i[rowIdx[RA-1:0]][colIdx[CA-1:0]];
        end
    end

endmodule

// File: rtl/playfield_memory.sv
// Tetris playfield store: height_p x width_p bit matrix with combinational
// line and piece-window reads, a row-by-row OR-merge piece lock, a
// sequential row-clear/collapse engine and single-cycle full-row writes.
// Optional sticky lock collision flag under PLAYFIELD_COLLISION_EN.
module playfield_memory
    import playfield_pkg::*;
#(
    parameter int width_p      = 10,
    parameter int height_p     = 20,
    parameter int piece_dim_p  = 4,
    parameter int line_ports_p = 2
)
(
    input  logic               clk_i,
    input  logic               reset_i,
    playfield_memory_if.slave  bus
);

    localparam int RA    = addrW(height_p);
    localparam int XW    = coordW(width_p);
    localparam int YW    = coordW(height_p);
    localparam int CA    = XW - 1;
    localparam int Cells = piece_dim_p * piece_dim_p;
    localparam int CntW  = addrW(piece_dim_p);

    state_e             state_q, state_d;
    logic [XW-1:0]      blkX_q, blkX_d;
    logic [YW-1:0]      blkY_q, blkY_d;
    logic [Cells-1:0]   blkData_q, blkData_d;
    logic [CntW-1:0]    rowCnt_q, rowCnt_d;
    logic [RA-1:0]      clrCnt_q, clrCnt_d;
    logic               clrNop_q, clrNop_d;
    logic [width_p-1:0] mem_q [height_p];
    logic [width_p-1:0] mem_d [height_p];

    logic               isIdle;
    logic               blkAcc, clrAcc, rowAcc;
    logic               doneNow;

    logic [piece_dim_p-1:0] pieceRow;
    logic [RA+1:0]          lockRow;
    logic                   lockRowOk;
    logic [CA+1:0]          lockCol [piece_dim_p];
    logic [piece_dim_p-1:0] lockColOk;
    logic [width_p-1:0]     lockMask;

    // Line read ports; an address past the last row reads as empty.
    for (genvar p = 0; p < line_ports_p; p++) begin : gLine
        logic [RA-1:0] lineAddr;
        assign lineAddr = bus.line_addr_i[p*RA +: RA];
        assign bus.line_data_o[p*width_p +: width_p] =
            (int'(lineAddr) < height_p) ? mem_q[lineAddr] : '0;
    end

    for (genvar k = 0; k < height_p; k++) begin : gFull
        assign bus.full_rows_o[k] = &mem_q[k];
    end

    playfield_window #(
        .width_p  (width_p),
        .height_p (height_p),
        .dim_p    (piece_dim_p)
    ) uRdWin (
        .mem_i  (mem_q),
        .x_i    (bus.blk_rd_x_i),
        .y_i    (bus.blk_rd_y_i),
        .data_o (bus.blk_rd_data_o)
    );

    // Handshake priority: lock beats clear beats row write, all only in IDLE.
    assign isIdle            = (state_q == eIDLE);
    assign bus.blk_w_ready_o = isIdle;
    assign bus.clr_ready_o   = isIdle && !bus.blk_w_v_i;
    assign bus.row_w_ready_o = isIdle && !bus.blk_w_v_i && !bus.clr_v_i;
    assign blkAcc            = bus.blk_w_v_i && bus.blk_w_ready_o;
    assign clrAcc            = bus.clr_v_i && bus.clr_ready_o;
    assign rowAcc            = bus.row_w_v_i && bus.row_w_ready_o;
    assign bus.done_o        = doneNow && !reset_i;

    // Target row and columns of the piece row being merged this cycle.
    assign pieceRow  = blkData_q[rowCnt_q*piece_dim_p +: piece_dim_p];
    assign lockRow   = {blkY_q[YW-1], blkY_q} + (RA+2)'(rowCnt_q);
    assign lockRowOk = !lockRow[RA+1] && (int'(lockRow) < height_p);

    for (genvar c = 0; c < piece_dim_p; c++) begin : gLockCol
        assign lockCol[c]   = {blkX_q[XW-1], blkX_q} + (CA+2)'(c);
        assign lockColOk[c] = !lockCol[c][CA+1] && (int'(lockCol[c]) < width_p);
    end

    // Scatter the in-range piece cells of the current row onto matrix columns.
    always_comb begin
        lockMask = '0;
        for (int c = 0; c < piece_dim_p; c++) begin
            if (lockColOk[c] && pieceRow[c]) begin
                lockMask[lockCol[c][CA-1:0]] = 1'b1;
            end
        end
    end

    // Controller next state: accept requests in IDLE, step lock and clear engines.
    always_comb begin
        state_d   = state_q;
        blkX_d    = blkX_q;
        blkY_d    = blkY_q;
        blkData_d = blkData_q;
        rowCnt_d  = rowCnt_q;
        clrCnt_d  = clrCnt_q;
        clrNop_d  = clrNop_q;
        doneNow   = 1'b0;
        for (int k = 0; k < height_p; k++) begin
            mem_d[k] = mem_q[k];
        end

        unique case (state_q)
            eIDLE: begin
                if (blkAcc) begin
                    state_d   = eBLOCK;
                    blkX_d    = bus.blk_w_x_i;
                    blkY_d    = bus.blk_w_y_i;
                    blkData_d = bus.blk_w_data_i;
                    rowCnt_d  = '0;
                end else if (clrAcc) begin
                    state_d  = eCLEAR;
                    clrCnt_d = bus.clr_row_i;
                    clrNop_d = (int'(bus.clr_row_i) >= height_p);
                end else if (rowAcc && (int'(bus.row_w_addr_i) < height_p)) begin
                    mem_d[bus.row_w_addr_i] = bus.row_w_data_i;
                end
            end

            eBLOCK: begin
                if (lockRowOk) begin
                    mem_d[lockRow[RA-1:0]] = mem_q[lockRow[RA-1:0]] | lockMask;
                end
                if (int'(rowCnt_q) == piece_dim_p - 1) begin
                    doneNow = 1'b1;
                    state_d = eIDLE;
                end else begin
                    rowCnt_d = rowCnt_q + CntW'(1);
                end
            end

            eCLEAR: begin
                if (clrNop_q) begin
                    doneNow = 1'b1;
                    state_d = eIDLE;
                end else begin
                    mem_d[clrCnt_q] = (clrCnt_q != '0) ? mem_q[clrCnt_q - RA'(1)] : '0;
                    if (clrCnt_q == '0) begin
                        doneNow = 1'b1;
                        state_d = eIDLE;
                    end else begin
                        clrCnt_d = clrCnt_q - RA'(1);
                    end
                end
            end

            default: begin
                state_d = eIDLE;
            end
        endcase
    end

    // State, latches and matrix registers with synchronous reset.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q   <= eIDLE;
            blkX_q    <= '0;
            blkY_q    <= '0;
            blkData_q <= '0;
            rowCnt_q  <= '0;
            clrCnt_q  <= '0;
            clrNop_q  <= 1'b0;
            for (int k = 0; k < height_p; k++) begin
                mem_q[k] <= '0;
            end
        end else begin
            state_q   <= state_d;
            blkX_q    <= blkX_d;
            blkY_q    <= blkY_d;
            blkData_q <= blkData_d;
            rowCnt_q  <= rowCnt_d;
            clrCnt_q  <= clrCnt_d;
            clrNop_q  <= clrNop_d;
            for (int k = 0; k < height_p; k++) begin
                mem_q[k] <= mem_d[k];
            end
        end
    end

`ifdef PLAYFIELD_COLLISION_EN
    logic [Cells-1:0] collWin;
    logic             rowHit;
    logic             collision_q, collision_d;

    // The row being merged still holds its pre-lock contents, so the window
    // over the latched origin shows exactly what the piece row lands on.
    playfield_window #(
        .width_p  (width_p),
        .height_p (height_p),
        .dim_p    (piece_dim_p)
    ) uCollWin (
        .mem_i  (mem_q),
        .x_i    (blkX_q),
        .y_i    (blkY_q),
        .data_o (collWin)
    );

    assign rowHit = !lockRow[RA+1] &&
                    (|(pieceRow & collWin[rowCnt_q*piece_dim_p +: piece_dim_p]));

    // Sticky collision flag, cleared at each lock accept.
    always_comb begin
        collision_d = collision_q;
        if (blkAcc) begin
            collision_d = 1'b0;
        end else if ((state_q == eBLOCK) && rowHit) begin
            collision_d = 1'b1;
        end
    end

    // Collision flag register.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            collision_q <= 1'b0;
        end else begin
            collision_q <= collision_d;
        end
    end

    assign bus.collision_o = collision_q;
`else
    assign bus.collision_o = 1'b0;
`endif

endmodule
